// File: rtl/ila_capture.sv
// Trigger-driven capture buffer for the {b_val, a_val} probe streams.
// Keeps PRETRIG samples of history, completes a DEPTH-sample window around the trigger, then freezes.
module ila_capture #(
    parameter int PW      = 10,
    parameter int DEPTH   = 64,
    parameter int AW      = 6,
    parameter int PRETRIG = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic [PW-1:0]   a_val,
    input  logic [PW-1:0]   b_val,
    input  logic [PW-1:0]   trig_a,
    input  logic [PW-1:0]   trig_b,
    input  logic            arm,
    input  logic            abort,
    input  logic [AW-1:0]   rd_addr,
    output logic [2*PW-1:0] rd_data,
    output logic            trig_seen,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {IDLE, ARMED, WAIT_TRIG, POST, DONE} state_t;

    localparam logic [AW-1:0] PRE_LAST  = AW'(PRETRIG - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRETRIG - 2);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRETRIG);

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   pre_cnt;
    logic [AW-1:0]   post_cnt;
    logic [AW-1:0]   trig_ptr;
    logic [AW-1:0]   win_start;
    logic [AW-1:0]   rd_ptr;
    logic            capturing;
    logic            wr_en;
    logic            hit;

    logic [2*PW-1:0] mem [DEPTH];

    assign capturing = (state == ARMED) || (state == WAIT_TRIG) || (state == POST);
    assign wr_en     = cen && capturing;
    assign hit       = (a_val == trig_a) && (b_val == trig_b);
    assign win_start = trig_ptr - PRE_OFS;
    assign rd_ptr    = win_start + rd_addr;

    // Memory array carries no reset so it maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {b_val, a_val};
        end
    end

    // Read register only loads once frozen, so it never picks up unwritten entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (done) begin
            rd_data <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            trig_ptr  <= '0;
            trig_seen <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            trig_seen <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (cen) begin
            case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        state     <= ARMED;
                        wr_ptr    <= '0;
                        pre_cnt   <= '0;
                        trig_seen <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                ARMED: begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    pre_cnt <= pre_cnt + 1'b1;
                    if (pre_cnt == PRE_LAST) begin
                        state <= WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (hit) begin
                        trig_ptr  <= wr_ptr;
                        trig_seen <= 1'b1;
                        post_cnt  <= '0;
                        state     <= POST;
                    end
                end
                POST: begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    post_cnt <= post_cnt + 1'b1;
                    if (post_cnt == POST_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ila_capture.sv
// Self-checking bench for ila_capture: directed scenarios plus randomized captures
// compared against a sample-list model of the capture window.
module tb_ila_capture;

    localparam int PW      = 10;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int PRETRIG = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            cen;
    logic [PW-1:0]   a_val;
    logic [PW-1:0]   b_val;
    logic [PW-1:0]   trig_a;
    logic [PW-1:0]   trig_b;
    logic            arm;
    logic            abort;
    logic [AW-1:0]   rd_addr;
    logic [2*PW-1:0] rd_data;
    logic            trig_seen;
    logic            busy;
    logic            done;

    ila_capture #(.PW(PW), .DEPTH(DEPTH), .AW(AW), .PRETRIG(PRETRIG)) dut (
        .clk(clk), .rst(rst), .cen(cen), .a_val(a_val), .b_val(b_val),
        .trig_a(trig_a), .trig_b(trig_b), .arm(arm), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data), .trig_seen(trig_seen),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: every sample written since arm, plus the index of the trigger sample.
    logic [2*PW-1:0] q[$];
    int              trig_idx;
    logic            m_active, m_done, m_seen;
    logic            toggle_cen, rand_mode;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_active = 1'b0; m_done = 1'b0; m_seen = 1'b0;
        q.delete(); trig_idx = -1;
    endtask

    task automatic model_edge();
        if (abort) begin
            model_clear();
        end else if (cen) begin
            if (!m_active && arm) begin
                model_clear();
                m_active = 1'b1;
            end else if (m_active) begin
                q.push_back({b_val, a_val});
                if (trig_idx < 0 && q.size() > PRETRIG && a_val == trig_a && b_val == trig_b) begin
                    trig_idx = q.size() - 1;
                    m_seen   = 1'b1;
                end
                if (trig_idx >= 0 && q.size() == trig_idx + DEPTH - PRETRIG) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("busy", {31'd0, busy}, {31'd0, m_active});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("trig_seen", {31'd0, trig_seen}, {31'd0, m_seen});
        a_val = a_val + PW'(1);
        if (toggle_cen) cen = ~cen;
        if (rand_mode) begin
            cen   = ($urandom_range(0, 3) != 0);
            b_val = PW'($urandom_range(0, 1));
            abort = ($urandom_range(0, 299) == 0);
        end
    endtask

    task automatic do_arm();
        cen = 1'b1; abort = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic run_to_done(input int max_cycles);
        int i;
        i = 0;
        while (!m_done && i < max_cycles) begin
            tick();
            i++;
        end
        chk("done_within_bound", {31'd0, done}, 32'd1);
        $display("[TB] capture trig_a=%0d done after %0d cycles", trig_a, i);
    endtask

    task automatic read_const(input logic [AW-1:0] addr, input logic [2*PW-1:0] exp);
        rd_addr = addr;
        tick();
        chk("rd_const", {12'd0, rd_data}, {12'd0, exp});
        $display("[TB] read rd_addr=%0d data=%0h", addr, rd_data);
    endtask

    task automatic read_window();
        if (trig_idx < 0) begin
            chk("window_model_trig", 32'd0, 32'd1);
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                rd_addr = AW'(k);
                tick();
                chk("rd_window", {12'd0, rd_data}, {12'd0, q[trig_idx - PRETRIG + k]});
            end
            $display("[TB] window read, first=%0h last=%0h", q[trig_idx - PRETRIG], q[trig_idx + DEPTH - PRETRIG - 1]);
        end
    endtask

    task automatic scen_basic();
        trig_a = PW'(20); trig_b = '0; b_val = '0; a_val = '0;
        do_arm();
        run_to_done(100);
        read_const(AW'(0), 20'd16);
        read_const(AW'(4), 20'd20);
        read_const(AW'(15), 20'd31);
        read_window();
    endtask

    initial begin
        rst = 1'b0; cen = 1'b0; a_val = '0; b_val = '0; trig_a = '0; trig_b = '0;
        arm = 1'b0; abort = 1'b0; rd_addr = '0; toggle_cen = 1'b0; rand_mode = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_trig_seen", {31'd0, trig_seen}, 32'd0);
        chk("rst_rd_data", {12'd0, rd_data}, 32'd0);
        rst = 1'b1;

        // Trigger after full history
        scen_basic();

        // Match during ARMED ignored, later trigger captures 36..51
        trig_a = PW'(2); trig_b = '0; a_val = '0;
        do_arm();
        repeat (100) tick();
        chk("armed_ignore_busy", {31'd0, busy}, 32'd1);
        chk("armed_ignore_done", {31'd0, done}, 32'd0);
        trig_a = PW'(40); a_val = '0;
        run_to_done(100);
        read_const(AW'(4), 20'd40);
        read_const(AW'(0), 20'd36);
        read_window();

        // cen gating: only even samples stored, odd trigger never fires
        trig_a = PW'(41); a_val = '0; cen = 1'b1; arm = 1'b1; toggle_cen = 1'b1;
        tick();
        arm = 1'b0;
        repeat (50) tick();
        chk("cen_gate_busy", {31'd0, busy}, 32'd1);
        chk("cen_gate_seen", {31'd0, trig_seen}, 32'd0);
        trig_a = PW'(60);
        run_to_done(100);
        toggle_cen = 1'b0; cen = 1'b1;
        read_const(AW'(0), 20'd52);
        read_const(AW'(1), 20'd54);
        read_window();

        // Abort beats arm in WAIT_TRIG
        trig_a = PW'(5); trig_b = PW'(7); a_val = '0;
        do_arm();
        repeat (10) tick();
        abort = 1'b1; arm = 1'b1;
        tick();
        abort = 1'b0; arm = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_seen", {31'd0, trig_seen}, 32'd0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("rearm_busy", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Async reset mid-POST
        trig_a = PW'(20); trig_b = '0; a_val = '0;
        do_arm();
        for (int i = 0; i < 100 && trig_idx < 0; i++) tick();
        repeat (3) tick();
        chk("pre_reset_in_post", {31'd0, busy & trig_seen}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_trig_seen", {31'd0, trig_seen}, 32'd0);
        chk("arst_rd_data", {12'd0, rd_data}, 32'd0);
        $display("[TB] async reset mid-POST applied");
        model_clear();
        #1;
        rst = 1'b1;
        scen_basic();

        // Re-arm from DONE with a wrapped write pointer
        trig_a = PW'(100); a_val = '0;
        do_arm();
        run_to_done(200);
        read_const(AW'(0), 20'd96);
        trig_a = PW'(200); a_val = PW'(150);
        do_arm();
        run_to_done(200);
        read_const(AW'(0), 20'd196);
        read_const(AW'(15), 20'd211);
        read_window();

        // Randomized captures
        for (int r = 0; r < 6; r++) begin
            trig_b = PW'($urandom_range(0, 1));
            a_val  = PW'($urandom_range(0, 500));
            trig_a = a_val + PW'($urandom_range(8, 150));
            b_val  = '0;
            do_arm();
            rand_mode = 1'b1;
            for (int i = 0; i < 600 && m_active; i++) tick();
            rand_mode = 1'b0; abort = 1'b0; cen = 1'b1;
            if (m_done) begin
                read_window();
            end else begin
                $display("[TB] random round %0d ended without capture", r);
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
